aes_out_serializer: RTL

Parametrised output serialiser for the AES datapath. It collects IN_W-bit result words from the core into BLK_W-bit blocks and buffers up to DEPTH complete blocks in a FIFO. Blocks are emitted MSB-first as OUT_W-bit symbols, each held for a programmable slot of 2^div_sel cycles with a mid-slot valid strobe. The block sits between the AES round core and the chip pins. Unlike the previous output port, it applies backpressure to the core, buffers back-to-back blocks, marks block starts, and optionally honours a downstream ready.

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_out_serializer_if.sv | 47 ++++
 rtl/aes_blk_fifo.sv | 76 +++++++
 rtl/aes_out_serializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES output path.
//   - default datapath widths (AES_BLK_W, AES_WORD_W)
//   - serialiser state encoding (ser_state_e)
//   - block geometry helpers: wpb() words per block, spb() symbols per block,
//     idx_w() index width that never collapses to zero bits
package aes_pkg;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_WORD_W = 32;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  function automatic int unsigned wpb(input int unsigned blk_w, input int unsigned in_w);
    return blk_w / in_w;
  endfunction

  function automatic int unsigned spb(input int unsigned blk_w, input int unsigned out_w);
    return blk_w / out_w;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// aes_out_serializer_if: core-side and pin-side signals of the serialiser.
//   pass_data/in_valid/in_ready : word handshake from the AES core
//   div_sel                     : slot-length exponent (latched per block)
//   out_ready                   : downstream ready, only with AES_OUT_READY_EN
//   out_data/out_valid/out_sof  : symbol, mid-slot strobe, block-start marker
//   busy                        : serialiser sending or blocks queued
// Modports: master drives the inputs of the serialiser, slave is the serialiser.
// Build option: `define AES_OUT_READY_EN adds out_ready.
interface aes_out_serializer_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned DIV_W = 4
);

  logic [IN_W-1:0]  pass_data;
  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] div_sel;
`ifdef AES_OUT_READY_EN
  logic             out_ready;
`endif
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_sof;
  logic             busy;

`ifdef AES_OUT_READY_EN
  modport master (
    output pass_data, in_valid, div_sel, out_ready,
    input  in_ready, out_data, out_valid, out_sof, busy
  );
  modport slave (
    input  pass_data, in_valid, div_sel, out_ready,
    output in_ready, out_data, out_valid, out_sof, busy
  );
`else
  modport master (
    output pass_data, in_valid, div_sel,
    input  in_ready, out_data, out_valid, out_sof, busy
  );
  modport slave (
    input  pass_data, in_valid, div_sel,
    output in_ready, out_data, out_valid, out_sof, busy
  );
`endif

endinterface

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: DEPTH x BLK_W synchronous block FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full unless popping too)
//   push_data  : block to enqueue
//   pop        : drop the head block (ignored when empty)
//   head_data  : oldest block, read straight from the storage flops
//   full/empty : occupancy flags of the current cycle
//   full_nxt   : occupancy flag after this cycle's push/pop
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int unsigned BLK_W = AES_BLK_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [BLK_W-1:0] push_data,
  input  logic             pop,
  output logic [BLK_W-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             full_nxt
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [BLK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // When full, the slot being popped is the one written, so a combined
  // push/pop is still safe.
  assign do_push  = push && (!full || do_pop);
  assign full_nxt = (count_nxt == CNT_W'(DEPTH));

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/aes_out_serializer.sv
// aes_out_serializer: collects IN_W-bit result words into BLK_W-bit blocks,
// queues up to DEPTH blocks and emits each block MSB-first as OUT_W-bit
// symbols, one symbol per slot of 2^div_sel cycles with a mid-slot strobe.
//   clk, rst : clock, synchronous active-high reset
//   bus      : aes_out_serializer_if.slave
//              pass_data/in_valid/in_ready core handshake (in_ready registered)
//              div_sel slot exponent, latched at each block load
//              out_data/out_valid/out_sof/busy registered pin-side outputs
//              out_ready downstream ready (AES_OUT_READY_EN builds only)
// Build option: `define AES_OUT_READY_EN makes each slot end wait for out_ready.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int unsigned BLK_W = AES_BLK_W,
  parameter int unsigned IN_W  = AES_WORD_W,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DIV_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  aes_out_serializer_if.slave bus
);

  localparam int unsigned WPB   = wpb(BLK_W, IN_W);
  localparam int unsigned SPB   = spb(BLK_W, OUT_W);
  localparam int unsigned WC_W  = idx_w(WPB);
  localparam int unsigned SI_W  = idx_w(SPB);
  localparam int unsigned CNT_W = (1 << DIV_W) - 1;

  // ---------------- collector ----------------
  logic [WC_W-1:0]  word_cnt;
  logic [BLK_W-1:0] asm_q;
  logic [BLK_W-1:0] asm_nxt;
  logic             in_ready_q;
  logic             accept;
  logic             last_word;

  // FIFO
  logic             push;
  logic             pop;
  logic [BLK_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_full_nxt;

  assign accept    = bus.in_valid && in_ready_q;
  assign last_word = accept && (word_cnt == WC_W'(WPB - 1));
  assign push      = last_word && !fifo_full;

  // asm_nxt already holds the word being accepted, so the final word of a
  // block can be pushed in its own acceptance cycle.
  always_comb begin
    asm_nxt = asm_q;
    for (int unsigned w = 0; w < WPB; w++) begin
      if (word_cnt == WC_W'(w)) begin
        asm_nxt[BLK_W - 1 - w * IN_W -: IN_W] = bus.pass_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt   <= '0;
      asm_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (accept) begin
        asm_q    <= asm_nxt;
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end
      in_ready_q <= !fifo_full_nxt;
    end
  end

  aes_blk_fifo #(
    .BLK_W (BLK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (asm_nxt),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_nxt  (fifo_full_nxt)
  );

  // ---------------- serialiser FSM ----------------
  ser_state_e       state;
  ser_state_e       state_nxt;
  logic [BLK_W-1:0] sr_q;
  logic [BLK_W-1:0] sr_nxt;
  logic [SI_W-1:0]  sym_idx;
  logic [SI_W-1:0]  sym_nxt;
  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] slot_nxt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  logic [CNT_W-1:0] slot_max;
  logic             slot_end;
  logic             advance;
  logic             valid_bit;

  always_comb begin
    slot_max = ~({CNT_W{1'b1}} << div_q);
  end

  assign slot_end = (slot_cnt == slot_max);

`ifdef AES_OUT_READY_EN
  assign advance = bus.out_ready;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr_q;
    sym_nxt   = sym_idx;
    slot_nxt  = slot_cnt;
    div_nxt   = div_q;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          sr_nxt    = fifo_head;
          div_nxt   = bus.div_sel;
          sym_nxt   = '0;
          slot_nxt  = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!slot_end) begin
          slot_nxt = slot_cnt + 1'b1;
        end else if (advance) begin
          if (sym_idx != SI_W'(SPB - 1)) begin
            sr_nxt   = sr_q << OUT_W;
            sym_nxt  = sym_idx + 1'b1;
            slot_nxt = '0;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            sr_nxt   = fifo_head;
            div_nxt  = bus.div_sel;
            sym_nxt  = '0;
            slot_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
        // Without advance the slot counter stays at its final value, which
        // also keeps the strobe high for the whole stall.
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr_q     <= '0;
      sym_idx  <= '0;
      slot_cnt <= '0;
      div_q    <= '0;
    end else begin
      state    <= state_nxt;
      sr_q     <= sr_nxt;
      sym_idx  <= sym_nxt;
      slot_cnt <= slot_nxt;
      div_q    <= div_nxt;
    end
  end

  // ---------------- registered outputs ----------------
  // Outputs trail the FSM by one register stage: a block popped at edge n
  // shows symbol 0 on the pins from edge n+1.
  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_sof_q;
  logic             busy_q;

  always_comb begin
    valid_bit = 1'b1;
    if (div_q != '0) begin
      valid_bit = slot_cnt[div_q - 1'b1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (state == SEND) out_data_q <= sr_q[BLK_W-1 -: OUT_W];
      out_valid_q <= (state == SEND) && valid_bit;
      out_sof_q   <= (state == SEND) && (sym_idx == '0);
      busy_q      <= (state == SEND) || !fifo_empty;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.busy      = busy_q;

endmodule
